// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the serial add/sub block: FSM states and mode constants.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Purely combinational 1-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH RUN cycles per op.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last;

  fa_cell u_fa (
    .a   (sa[0]),
    .b   (sb[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
            sa    <= a;
            sb    <= (sub == MODE_SUB) ? ~b : b;
            carry <= (sub == MODE_SUB);
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= {fa_s, acc[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= fa_c;
          if (last) begin
            result <= {fa_s, acc[WIDTH-1:1]};
            cout   <= fa_c;
            ovf    <= carry ^ fa_c;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
